// File: rtl/player_motion_controller.sv
// player_motion_controller
// Turns per-frame jump/walk decisions into a character position. Physics
// advance once per rising edge of the 60 Hz frame tick: a ground/rise/fall
// jump FSM with integer gravity, a wrapping horizontal walk counter, and
// one-cycle status strobes following every frame update.

module player_motion_controller #(
    parameter int X_MAX     = 159,
    parameter int GROUND_Y  = 100,
    parameter int JUMP_VEL  = 12,
    parameter int GRAVITY   = 1,
    parameter int WALK_STEP = 1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       clk_60hz,
    input  logic       jump,
    input  logic       walk,
    output logic [7:0] x_pos,
    output logic [6:0] y_pos,
    output logic       airborne,
    output logic       frame_done,
    output logic       landed
);

    typedef enum logic [1:0] {
        ST_GROUND = 2'b00,
        ST_RISE   = 2'b01,
        ST_FALL   = 2'b10
    } state_t;

    // Parameters narrowed once to the datapath widths they are compared with.
    localparam logic [8:0] X_MAX_C  = 9'(X_MAX);
    localparam logic [8:0] X_WRAP_C = 9'(X_MAX + 1);
    localparam logic [8:0] WALK_C   = 9'(WALK_STEP);
    localparam logic [6:0] GROUND_C = 7'(GROUND_Y);
    localparam logic [4:0] JUMP_C   = 5'(JUMP_VEL);
    localparam logic [4:0] GRAV_C   = 5'(GRAVITY);

    state_t      state_r;
    state_t      state_next_s;
    logic        tick_r;
    logic        frame_s;
    logic [6:0]  height_r;
    logic [6:0]  height_next_s;
    logic [4:0]  vel_r;
    logic [4:0]  vel_next_s;
    logic [7:0]  x_r;
    logic [7:0]  x_next_s;
    logic [8:0]  x_sum_s;
    logic [7:0]  rise_sum_s;
    logic [5:0]  fall_nv_s;
    logic        landed_next_s;
    logic        airborne_r;
    logic        frame_done_r;
    logic        landed_r;

    // tick_r resets high so a tick already high at reset release is not a frame.
    assign frame_s    = clk_60hz & ~tick_r;

    // One extra bit on every intermediate sum keeps carries visible.
    assign x_sum_s    = {1'b0, x_r} + WALK_C;
    assign rise_sum_s = {1'b0, height_r} + {3'b000, vel_r};
    assign fall_nv_s  = {1'b0, vel_r} + {1'b0, GRAV_C};

    // Next jump state, height, speed and landing strobe; holds unless a frame.
    always_comb begin
        state_next_s  = state_r;
        height_next_s = height_r;
        vel_next_s    = vel_r;
        landed_next_s = 1'b0;
        if (frame_s) begin
            case (state_r)
                ST_GROUND: begin
                    if (jump) begin
                        vel_next_s   = JUMP_C;
                        state_next_s = ST_RISE;
                    end else begin
                        state_next_s = ST_GROUND;
                    end
                end
                ST_RISE: begin
                    // Saturate rather than wrap if a parameter set overshoots 7 bits.
                    if (rise_sum_s[7]) begin
                        height_next_s = 7'h7F;
                    end else begin
                        height_next_s = rise_sum_s[6:0];
                    end
                    // Clamp at zero so an odd gravity never underflows the speed.
                    if (vel_r > GRAV_C) begin
                        vel_next_s = vel_r - GRAV_C;
                    end else begin
                        vel_next_s = 5'd0;
                    end
                    if (vel_next_s == 5'd0) begin
                        state_next_s = ST_FALL;
                    end else begin
                        state_next_s = ST_RISE;
                    end
                end
                ST_FALL: begin
                    if ({1'b0, height_r} <= {2'b00, fall_nv_s}) begin
                        height_next_s = 7'd0;
                        vel_next_s    = 5'd0;
                        state_next_s  = ST_GROUND;
                        landed_next_s = 1'b1;
                    end else begin
                        height_next_s = height_r - {1'b0, fall_nv_s};
                        if (fall_nv_s[5]) begin
                            vel_next_s = 5'd31;
                        end else begin
                            vel_next_s = fall_nv_s[4:0];
                        end
                        state_next_s = ST_FALL;
                    end
                end
                default: begin
                    // Unreachable encoding: recover safely to standing on the ground.
                    height_next_s = 7'd0;
                    vel_next_s    = 5'd0;
                    state_next_s  = ST_GROUND;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Next horizontal position: step on walking frames, wrap past X_MAX.
    always_comb begin
        x_next_s = x_r;
        if (frame_s && walk) begin
            if (x_sum_s > X_MAX_C) begin
                x_next_s = 8'(x_sum_s - X_WRAP_C);
            end else begin
                x_next_s = 8'(x_sum_s);
            end
        end else begin
            x_next_s = x_r;
        end
    end

    // Jump FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r <= ST_GROUND;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath, tick history and registered status strobes.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            tick_r       <= 1'b1;
            height_r     <= 7'd0;
            vel_r        <= 5'd0;
            x_r          <= 8'd0;
            airborne_r   <= 1'b0;
            frame_done_r <= 1'b0;
            landed_r     <= 1'b0;
        end else begin
            tick_r       <= clk_60hz;
            height_r     <= height_next_s;
            vel_r        <= vel_next_s;
            x_r          <= x_next_s;
            airborne_r   <= (state_next_s != ST_GROUND);
            frame_done_r <= frame_s;
            landed_r     <= landed_next_s;
        end
    end

    assign x_pos      = x_r;
    assign y_pos      = GROUND_C - height_r;
    assign airborne   = airborne_r;
    assign frame_done = frame_done_r;
    assign landed     = landed_r;

endmodule
